seq_scan_arbiter: RTL and testbench

- Shares one 3-bit-symbol sequence detector between NUM_REQ requesters.
- Each requester presents a packed frame of FRAME_LEN symbols. The controller grants requesters round-robin and restarts the detector before every frame.
- It streams the frame into the detector one symbol per clock, captures whether and where the detector fired, and returns the result to the granted requester with a one-cycle done pulse.

---
 rtl/seq_scan_arbiter_if.sv | 43 ++++
 rtl/seq_scan_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_seq_scan_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_scan_arbiter_if.sv
// -----------------------------------------------------------------------------
// seq_scan_arbiter_if
// Bundles the requester-side bus and the detector-side bus of the shared
// sequence-detector arbiter.
//   req        : per-requester request, held until the matching done bit
//   frame_in   : packed frames, requester r at [r*FRAME_LEN*3 +: FRAME_LEN*3]
//   done       : one-hot, one-cycle completion pulse
//   busy       : arbiter is working on a frame
//   gnt_id     : index of the current or last granted requester
//   result_hit : detector fired during the frame (valid with done)
//   result_idx : first symbol index on which it fired (valid with done)
//   det_rst_n  : active-low reset to the shared detector
//   det_data   : symbol presented to the detector
//   det_found  : combinational match flag from the detector
// Modports: slave = the arbiter, master = requesters plus detector.
// -----------------------------------------------------------------------------
interface seq_scan_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int FRAME_LEN = 8,
    parameter int ID_W      = 2,
    parameter int IDX_W     = 4
);
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ*FRAME_LEN*3-1:0] frame_in;
    logic [NUM_REQ-1:0]             done;
    logic                           busy;
    logic [ID_W-1:0]                gnt_id;
    logic                           result_hit;
    logic [IDX_W-1:0]               result_idx;
    logic                           det_rst_n;
    logic [2:0]                     det_data;
    logic                           det_found;

    modport slave (
        input  req, frame_in, det_found,
        output done, busy, gnt_id, result_hit, result_idx, det_rst_n, det_data
    );

    modport master (
        output req, frame_in, det_found,
        input  done, busy, gnt_id, result_hit, result_idx, det_rst_n, det_data
    );
endinterface

// File: rtl/seq_scan_arbiter.sv
// -----------------------------------------------------------------------------
// seq_scan_arbiter
// Time-shares one 3-bit-symbol sequence detector between NUM_REQ requesters.
// Requesters are granted round-robin; for each grant the detector is reset
// for one cycle, the latched frame is streamed in one symbol per clock
// (symbol 0 first), the first firing position is captured, and the result is
// returned with a one-cycle one-hot done pulse.
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : seq_scan_arbiter_if.slave (requester and detector signals)
// Every output is driven straight from a register.
// -----------------------------------------------------------------------------
module seq_scan_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int FRAME_LEN = 8,
    parameter int ID_W      = 2,
    parameter int IDX_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    seq_scan_arbiter_if.slave    bus
);
    localparam int FW = FRAME_LEN * 3;   // bits per frame
    localparam int SW = ID_W + 1;        // room for rr_ptr + offset before wrap

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [FW-1:0]      shift_q, shift_d;
    logic [IDX_W-1:0]   count_q, count_d;
    logic               hit_q, hit_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic               result_hit_q, result_hit_d;
    logic [IDX_W-1:0]   result_idx_q, result_idx_d;
    logic               det_rst_n_q, det_rst_n_d;
    logic [2:0]         det_data_q, det_data_d;

    // Per-requester view of the packed frame bus.
    logic [FW-1:0]      frames [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign frames[gi] = bus.frame_in[gi*FW +: FW];
    end

    // -------------------------------------------------------------------------
    // Round-robin pick: first requesting index at or above rr_ptr, wrapping.
    // Offsets are visited from largest to smallest so the smallest offset
    // with an active request is the one left in pick.
    // -------------------------------------------------------------------------
    logic            req_any;
    logic [ID_W-1:0] pick;

    always_comb begin
        logic [SW-1:0] sum;
        req_any = 1'b0;
        pick    = '0;
        sum     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr_q} + SW'(i);
            if (sum >= SW'(NUM_REQ)) begin
                sum = sum - SW'(NUM_REQ);
            end
            if (bus.req[sum[ID_W-1:0]]) begin
                req_any = 1'b1;
                pick    = sum[ID_W-1:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic.
    // -------------------------------------------------------------------------
    logic last_sym;
    assign last_sym = (count_q == IDX_W'(FRAME_LEN - 1));

    always_comb begin
        state_d      = state_q;
        gnt_id_d     = gnt_id_q;
        rr_ptr_d     = rr_ptr_q;
        shift_d      = shift_q;
        count_d      = count_q;
        hit_d        = hit_q;
        idx_d        = idx_q;
        done_d       = '0;
        result_hit_d = result_hit_q;
        result_idx_d = result_idx_q;
        det_data_d   = 3'd0;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d  = CLEAR;
                    gnt_id_d = pick;
                    shift_d  = frames[pick];
                    rr_ptr_d = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                    hit_d    = 1'b0;
                    idx_d    = '0;
                end
            end

            CLEAR: begin
                // Preload symbol 0 so it is on det_data in the first STREAM cycle.
                state_d    = STREAM;
                count_d    = '0;
                det_data_d = shift_q[2:0];
                shift_d    = shift_q >> 3;
            end

            STREAM: begin
                // det_found here belongs to the symbol indexed by count_q.
                if (bus.det_found && !hit_q) begin
                    hit_d = 1'b1;
                    idx_d = count_q;
                end
                count_d = count_q + 1'b1;
                if (last_sym) begin
                    state_d      = REPORT;
                    done_d       = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id_q;
                    result_hit_d = hit_d;
                    result_idx_d = idx_d;
                    det_data_d   = 3'd0;
                end else begin
                    det_data_d = shift_q[2:0];
                    shift_d    = shift_q >> 3;
                end
            end

            REPORT: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Both flags describe the state being entered, so they line up with it.
        busy_d      = (state_d != IDLE);
        det_rst_n_d = (state_d != CLEAR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            gnt_id_q     <= '0;
            rr_ptr_q     <= '0;
            shift_q      <= '0;
            count_q      <= '0;
            hit_q        <= 1'b0;
            idx_q        <= '0;
            done_q       <= '0;
            busy_q       <= 1'b0;
            result_hit_q <= 1'b0;
            result_idx_q <= '0;
            det_rst_n_q  <= 1'b0;
            det_data_q   <= 3'd0;
        end else begin
            state_q      <= state_d;
            gnt_id_q     <= gnt_id_d;
            rr_ptr_q     <= rr_ptr_d;
            shift_q      <= shift_d;
            count_q      <= count_d;
            hit_q        <= hit_d;
            idx_q        <= idx_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            result_hit_q <= result_hit_d;
            result_idx_q <= result_idx_d;
            det_rst_n_q  <= det_rst_n_d;
            det_data_q   <= det_data_d;
        end
    end

    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.gnt_id     = gnt_id_q;
    assign bus.result_hit = result_hit_q;
    assign bus.result_idx = result_idx_q;
    assign bus.det_rst_n  = det_rst_n_q;
    assign bus.det_data   = det_data_q;

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seq_scan_arbiter
// Directed and randomized bench for seq_scan_arbiter. A small behavioural
// detector (fires on 110,110,011 since its last reset) is attached to the
// detector bus. Expected grants, timing and results come from a round-robin
// model plus a plain scan of the latched frame.
// -----------------------------------------------------------------------------
module tb_seq_scan_arbiter;
    localparam int NR  = 4;
    localparam int FL  = 8;
    localparam int IDW = 2;
    localparam int IXW = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    seq_scan_arbiter_if #(.NUM_REQ(NR), .FRAME_LEN(FL), .ID_W(IDW), .IDX_W(IXW)) bus_if ();

    seq_scan_arbiter #(.NUM_REQ(NR), .FRAME_LEN(FL), .ID_W(IDW), .IDX_W(IXW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    // Behavioural detector: remembers the last two symbols since its reset.
    logic [2:0] h1 = 3'd0;
    logic [2:0] h2 = 3'd0;
    int         hv = 0;

    always @(posedge clk or negedge bus_if.det_rst_n) begin
        if (!bus_if.det_rst_n) begin
            h1 <= 3'd0;
            h2 <= 3'd0;
            hv <= 0;
        end else begin
            h2 <= h1;
            h1 <= bus_if.det_data;
            hv <= (hv >= 2) ? 2 : hv + 1;
        end
    end

    assign bus_if.det_found = (hv >= 2) && (h2 == 3'b110) && (h1 == 3'b110)
                              && (bus_if.det_data == 3'b011);

    // -------------------------------------------------------------------------
    // Bench state and reference model
    // -------------------------------------------------------------------------
    int         tests = 0;
    int         fails = 0;
    int         rr_model = 0;
    logic [2:0] fsym [NR][FL];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First position k where symbols k-2..k read 110,110,011.
    task automatic model_scan(input logic [2:0] s [FL], output logic hit, output int idx);
        hit = 1'b0;
        idx = 0;
        for (int k = 2; k < FL; k++) begin
            if (!hit && s[k-2] == 3'b110 && s[k-1] == 3'b110 && s[k] == 3'b011) begin
                hit = 1'b1;
                idx = k;
            end
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] rq);
        for (int i = 0; i < NR; i++) begin
            if (rq[(rr_model + i) % NR]) return (rr_model + i) % NR;
        end
        return -1;
    endfunction

    task automatic drive_frame(input int r);
        for (int k = 0; k < FL; k++) begin
            bus_if.frame_in[(r*FL + k)*3 +: 3] = fsym[r][k];
        end
    endtask

    function automatic logic [2:0] rand_sym();
        case ($urandom_range(0, 3))
            0:       return 3'($urandom);
            1:       return 3'b011;
            default: return 3'b110;
        endcase
    endfunction

    // Called mid-cycle in the IDLE cycle where the grant is made (cycle 0).
    // Follows one frame to the cycle after its done pulse, dropping the
    // served request at done. With corrupt set, the granted slice is zeroed
    // in cycle 3 to show the latched copy is what gets streamed.
    task automatic check_frame(input bit corrupt);
        int         r;
        logic [2:0] lat [FL];
        logic       eh;
        int         ei;
        r = rr_pick(bus_if.req);
        if (r < 0) begin
            chk("no_request_pending", 32'(bus_if.req), 32'hF);
            r = 0;
        end
        lat      = fsym[r];
        rr_model = (r + 1) % NR;
        model_scan(lat, eh, ei);

        chk("c0_busy", 32'(bus_if.busy), 32'd0);
        @(negedge clk);
        chk("c1_det_rst_n", 32'(bus_if.det_rst_n), 32'd0);
        chk("c1_busy", 32'(bus_if.busy), 32'd1);
        chk("c1_gnt_id", 32'(bus_if.gnt_id), 32'(r));
        for (int k = 0; k < FL; k++) begin
            @(negedge clk);
            chk($sformatf("stream%0d_det_data", k), 32'(bus_if.det_data), 32'(lat[k]));
            chk($sformatf("stream%0d_det_rst_n", k), 32'(bus_if.det_rst_n), 32'd1);
            chk($sformatf("stream%0d_done", k), 32'(bus_if.done), 32'd0);
            if (corrupt && k == 1) begin
                for (int j = 0; j < FL; j++) fsym[r][j] = 3'd0;
                drive_frame(r);
            end
        end
        @(negedge clk);
        chk("report_done", 32'(bus_if.done), 32'(1 << r));
        chk("report_hit", 32'(bus_if.result_hit), 32'(eh));
        chk("report_idx", 32'(bus_if.result_idx), 32'(ei));
        chk("report_gnt_id", 32'(bus_if.gnt_id), 32'(r));
        $display("[TB] frame r=%0d hit=%0d idx=%0d (model hit=%0d idx=%0d)",
                 r, bus_if.result_hit, bus_if.result_idx, eh, ei);
        bus_if.req[r] = 1'b0;
        @(negedge clk);
        chk("after_done_clear", 32'(bus_if.done), 32'd0);
        chk("after_busy_low", 32'(bus_if.busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_done", 32'(bus_if.done), 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_gnt_id", 32'(bus_if.gnt_id), 32'd0);
        chk("rst_hit", 32'(bus_if.result_hit), 32'd0);
        chk("rst_idx", 32'(bus_if.result_idx), 32'd0);
        chk("rst_det_rst_n", 32'(bus_if.det_rst_n), 32'd0);
        chk("rst_det_data", 32'(bus_if.det_data), 32'd0);
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        rr_model = 0;
    endtask

    localparam logic [23:0] PAT1 = {3'b000, 3'b011, 3'b110, 3'b110,
                                    3'b000, 3'b110, 3'b101, 3'b001};
    localparam logic [23:0] PAT2 = {3'b011, 3'b110, 3'b110, 3'b000,
                                    3'b110, 3'b101, 3'b001, 3'b111};

    initial begin
        logic [23:0] p1, p2;
        p1 = PAT1;
        p2 = PAT2;
        bus_if.req      = '0;
        bus_if.frame_in = '0;
        for (int r = 0; r < NR; r++) begin
            for (int k = 0; k < FL; k++) begin
                case (r)
                    0:       fsym[r][k] = p1[3*k +: 3];
                    1:       fsym[r][k] = p2[3*k +: 3];
                    2:       fsym[r][k] = 3'd0;
                    default: fsym[r][k] = rand_sym();
                endcase
            end
            drive_frame(r);
        end

        do_reset();

        // Single requesters 0, 1, 2 with the directed frames.
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            bus_if.req[r] = 1'b1;
            check_frame(1'b0);
        end

        // All four requesting at once from a fresh pointer.
        do_reset();
        @(negedge clk);
        bus_if.req = 4'b1111;
        for (int n = 0; n < NR; n++) check_frame(1'b0);

        // Reset in cycle 5 of a requester-3 frame.
        @(negedge clk);
        bus_if.req = 4'b1000;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_done", 32'(bus_if.done), 32'd0);
        chk("abort_busy", 32'(bus_if.busy), 32'd0);
        chk("abort_det_rst_n", 32'(bus_if.det_rst_n), 32'd0);
        bus_if.req = 4'b0101;
        repeat (3) begin
            @(negedge clk);
            chk("abort_hold_done", 32'(bus_if.done), 32'd0);
            chk("abort_hold_det_rst_n", 32'(bus_if.det_rst_n), 32'd0);
        end
        reset_n  = 1'b1;
        rr_model = 0;
        check_frame(1'b0);
        check_frame(1'b0);

        // frame_in changed after the grant edge.
        @(negedge clk);
        bus_if.req[0] = 1'b1;
        check_frame(1'b1);

        // Randomized request sets and frames.
        for (int round = 0; round < 6; round++) begin
            for (int r = 0; r < NR; r++) begin
                for (int k = 0; k < FL; k++) fsym[r][k] = rand_sym();
                drive_frame(r);
            end
            @(negedge clk);
            bus_if.req = 4'($urandom_range(1, 15));
            while (bus_if.req != '0) check_frame(1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
